// File: rtl/cfa_defs.sv
// Shared encodings for the CFA window controller: FSM states, Bayer
// pattern codes, centre-pixel colour codes and the phase helper.
package cfa_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_e;

  typedef enum logic [1:0] {
    PH_R  = 2'd0,
    PH_GR = 2'd1,
    PH_GB = 2'd2,
    PH_B  = 2'd3
  } phase_e;

  // Row parity flips R/B rows, column parity flips within a row.
  function automatic phase_e cfa_phase_f(input logic row_lsb, input logic col_lsb,
                                         input bayer_e bayer);
    logic [1:0] code;
    code = {row_lsb ^ bayer[1], col_lsb ^ bayer[0]};
    return phase_e'(code);
  endfunction

endpackage

// File: rtl/cfa_raster_cnt.sv
// Raster column/row position counter bounded by the latched frame size.
// Holds at the last pixel of the frame until cleared.
module cfa_raster_cnt #(
  parameter int ColBits = 11,
  parameter int RowBits = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [ColBits-1:0] width,
  input  logic [RowBits-1:0] height,
  output logic [ColBits-1:0] col,
  output logic [RowBits-1:0] row,
  output logic               last_col,
  output logic               last_pix
);

  logic [ColBits-1:0] col_r;
  logic [RowBits-1:0] row_r;
  logic               last_col_s;
  logic               last_row_s;

  assign last_col_s = (col_r == (width - ColBits'(1)));
  assign last_row_s = (row_r == (height - RowBits'(1)));

  // Position register: advance one pixel per enable, wrap column at row end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (clr) begin
      col_r <= '0;
      row_r <= '0;
    end else if (en && !(last_col_s && last_row_s)) begin
      if (last_col_s) begin
        col_r <= '0;
        row_r <= row_r + RowBits'(1);
      end else begin
        col_r <= col_r + ColBits'(1);
      end
    end
  end

  assign col      = col_r;
  assign row      = row_r;
  assign last_col = last_col_s;
  assign last_pix = last_col_s && last_row_s;

endmodule

// File: rtl/cfa_window_ctrl.sv
// Raster-scan sequencer for the CFA 2D window buffer: pixel handshake,
// buffer enable/reset, window-valid flag and centre/phase tagging.
module cfa_window_ctrl
  import cfa_defs::*;
#(
  parameter int FilterSize = 3,
  parameter int ColBits    = 11,
  parameter int RowBits    = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ColBits-1:0] cfg_width,
  input  logic [RowBits-1:0] cfg_height,
  input  logic [1:0]         cfg_bayer,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               buf_en,
  output logic               buf_rst,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [RowBits-1:0] win_row,
  output logic [ColBits-1:0] win_col,
  output logic [1:0]         cfa_phase,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam logic [ColBits-1:0] MIN_W         = ColBits'(FilterSize);
  localparam logic [RowBits-1:0] MIN_H         = RowBits'(FilterSize);
  localparam logic [ColBits-1:0] COL_FIRST     = ColBits'(FilterSize - 1);
  localparam logic [RowBits-1:0] ROW_FIRST     = RowBits'(FilterSize - 1);
  localparam logic [RowBits-1:0] ROW_LAST_FILL = RowBits'(FilterSize - 2);
  localparam logic [ColBits-1:0] COL_HALF      = ColBits'(FilterSize / 2);
  localparam logic [RowBits-1:0] ROW_HALF      = RowBits'(FilterSize / 2);

  state_e             state_r;
  state_e             state_nx_s;
  logic [ColBits-1:0] width_r;
  logic [RowBits-1:0] height_r;
  bayer_e             bayer_r;

  logic [ColBits-1:0] col_s;
  logic [RowBits-1:0] row_s;
  logic               last_col_s;
  logic               last_pix_s;

  logic               s_ready_s;
  logic               buf_rst_s;
  logic               busy_s;
  logic               done_go_s;
  logic               accept_s;
  logic               cfg_ok_s;
  logic               win_hit_s;
  logic [RowBits-1:0] new_row_s;
  logic [ColBits-1:0] new_col_s;

  logic               m_valid_r;
  logic [RowBits-1:0] win_row_r;
  logic [ColBits-1:0] win_col_r;
  phase_e             cfa_phase_r;
  logic               frame_done_r;
  logic               cfg_err_r;

  assign cfg_ok_s  = (cfg_width >= MIN_W) && (cfg_height >= MIN_H);
  assign accept_s  = s_valid && s_ready_s;
  assign win_hit_s = accept_s && (row_s >= ROW_FIRST) && (col_s >= COL_FIRST);
  assign new_row_s = row_s - ROW_HALF;
  assign new_col_s = col_s - COL_HALF;

  cfa_raster_cnt #(
    .ColBits (ColBits),
    .RowBits (RowBits)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (buf_rst_s),
    .en       (accept_s),
    .width    (width_r),
    .height   (height_r),
    .col      (col_s),
    .row      (row_s),
    .last_col (last_col_s),
    .last_pix (last_pix_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && cfg_ok_s) state_nx_s = ST_CLEAR;
        else                   state_nx_s = ST_IDLE;
      end
      ST_CLEAR: state_nx_s = ST_FILL;
      ST_FILL: begin
        if (accept_s && last_col_s && (row_s == ROW_LAST_FILL)) state_nx_s = ST_RUN;
        else                                                     state_nx_s = ST_FILL;
      end
      ST_RUN: begin
        if (accept_s && last_pix_s) state_nx_s = ST_DONE;
        else                        state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        if (done_go_s) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs; a pending window blocks intake until downstream takes it.
  always_comb begin
    s_ready_s = 1'b0;
    buf_rst_s = 1'b0;
    busy_s    = 1'b1;
    done_go_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        buf_rst_s = 1'b1;
        busy_s    = 1'b0;
      end
      ST_CLEAR: buf_rst_s = 1'b1;
      ST_FILL, ST_RUN: s_ready_s = !m_valid_r || m_ready;
      ST_DONE: done_go_s = !m_valid_r || m_ready;
      default: begin
        buf_rst_s = 1'b1;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Frame configuration captured on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_r  <= '0;
      height_r <= '0;
      bayer_r  <= BAYER_RGGB;
    end else if ((state_r == ST_IDLE) && start && cfg_ok_s) begin
      width_r  <= cfg_width;
      height_r <= cfg_height;
      bayer_r  <= bayer_e'(cfg_bayer);
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      frame_done_r <= (state_r == ST_DONE) && done_go_s;
      cfg_err_r    <= (state_r == ST_IDLE) && start && !cfg_ok_s;
    end
  end

  // Window valid and tags; a new window arriving with m_ready replaces the old one without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_r   <= 1'b0;
      win_row_r   <= '0;
      win_col_r   <= '0;
      cfa_phase_r <= PH_R;
    end else if (win_hit_s) begin
      m_valid_r   <= 1'b1;
      win_row_r   <= new_row_s;
      win_col_r   <= new_col_s;
      cfa_phase_r <= cfa_phase_f(new_row_s[0], new_col_s[0], bayer_r);
    end else if (m_ready) begin
      m_valid_r   <= 1'b0;
    end
  end

  assign s_ready    = s_ready_s;
  assign buf_en     = accept_s;
  assign buf_rst    = buf_rst_s;
  assign busy       = busy_s;
  assign m_valid    = m_valid_r;
  assign win_row    = win_row_r;
  assign win_col    = win_col_r;
  assign cfa_phase  = cfa_phase_r;
  assign frame_done = frame_done_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_cfa_window_ctrl.sv
// Scoreboard bench for cfa_window_ctrl: expected windows are queued per frame
// from the Bayer tile table; a negedge monitor pops and compares.
module tb_cfa_window_ctrl;

  localparam int F  = 3;
  localparam int CB = 11;
  localparam int RB = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CB-1:0] cfg_width = '0;
  logic [RB-1:0] cfg_height = '0;
  logic [1:0]    cfg_bayer = 2'd0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_ready, buf_en, buf_rst, m_valid, busy, frame_done, cfg_err;
  logic [RB-1:0] win_row;
  logic [CB-1:0] win_col;
  logic [1:0]    cfa_phase;

  typedef struct {
    int r;
    int c;
    int ph;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;
  int   win_cnt = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic prev_fd = 1'b0;
  int   tile[4][4];

  always #5 clk = ~clk;

  cfa_window_ctrl #(.FilterSize(F), .ColBits(CB), .RowBits(RB)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_bayer(cfg_bayer), .s_valid(s_valid), .s_ready(s_ready), .buf_en(buf_en),
    .buf_rst(buf_rst), .m_valid(m_valid), .m_ready(m_ready), .win_row(win_row),
    .win_col(win_col), .cfa_phase(cfa_phase), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: counts accepts/pulses and scores every presented window.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (buf_en) acc_cnt++;
        if (cfg_err) err_cnt++;
        if (frame_done) begin
          done_cnt++;
          check("frame_done_busy", 32'(busy), 32'd0);
          check("frame_done_single", 32'(prev_fd), 32'd0);
        end
        prev_fd = frame_done;
        if (m_valid) begin
          check("window_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            check("win_row", 32'(win_row), 32'(exp_q[0].r));
            check("win_col", 32'(win_col), 32'(exp_q[0].c));
            check("cfa_phase", 32'(cfa_phase), 32'(exp_q[0].ph));
            if (m_ready) begin
              void'(exp_q.pop_front());
              win_cnt++;
            end
          end
          if (!m_ready) check("stall_blocks_source", 32'({s_ready, buf_en}), 32'd0);
        end
        check("buf_en_is_accept", 32'(buf_en), 32'(s_valid && s_ready));
      end
    end
  end

  task automatic run_frame(input int w, input int h, input int bay, input int pv,
                           input int pr, input bit stall, input int abort_at);
    int   acc0, done0, win0, err0, cyc, stall_n;
    bit   aborted;
    win_t e;
    acc0 = acc_cnt; done0 = done_cnt; win0 = win_cnt; err0 = err_cnt;
    cyc = 0; stall_n = 0; aborted = 1'b0;
    for (int r = F - 1; r < h; r++) begin
      for (int c = F - 1; c < w; c++) begin
        e.r  = r - F / 2;
        e.c  = c - F / 2;
        e.ph = tile[bay][(e.r % 2) * 2 + (e.c % 2)];
        exp_q.push_back(e);
      end
    end
    start = 1'b1; cfg_width = CB'(w); cfg_height = RB'(h); cfg_bayer = 2'(bay);
    s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clear_state", 32'({busy, buf_rst, s_ready}), 32'd6);
    while (done_cnt == done0 && cyc < 5000 && !aborted) begin
      cfg_width  = CB'($urandom);
      cfg_height = RB'($urandom);
      cfg_bayer  = 2'($urandom);
      s_valid = ($urandom_range(99) < pv);
      m_ready = ($urandom_range(99) < pr);
      if (stall && m_valid && stall_n < 5) begin
        m_ready = 1'b0;
        stall_n++;
      end
      if (acc_cnt - acc0 >= 1 && acc_cnt - acc0 <= w * h - 2) start = ($urandom_range(7) == 0);
      else start = 1'b0;
      if (abort_at > 0 && acc_cnt - acc0 >= abort_at) begin
        s_valid = 1'b0; start = 1'b0; rst = 1'b0;
        #1;
        check("abort_outputs", 32'({m_valid, busy, buf_rst, buf_en}), 32'd2);
        exp_q.delete();
        aborted = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0; s_valid = 1'b0;
    if (!aborted) begin
      check("frame_done_seen", 32'(done_cnt - done0), 32'd1);
      check("frame_accepts", 32'(acc_cnt - acc0), 32'(w * h));
      check("frame_windows", 32'(win_cnt - win0), 32'((w - F + 1) * (h - F + 1)));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("no_cfg_err_busy", 32'(err_cnt - err0), 32'd0);
      check("idle_after_frame", 32'({busy, buf_rst}), 32'd1);
      if (stall) check("stall_cycles", 32'(stall_n), 32'd5);
    end
  endtask

  task automatic bad_start(input int w, input int h);
    int err0, acc0;
    err0 = err_cnt; acc0 = acc_cnt;
    start = 1'b1; cfg_width = CB'(w); cfg_height = RB'(h); s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check("cfg_err_idle", 32'({busy, buf_rst}), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("cfg_err_count", 32'(err_cnt - err0), 32'd1);
    check("cfg_err_no_accept", 32'(acc_cnt - acc0), 32'd0);
    s_valid = 1'b0;
  endtask

  initial begin
    // Colour at (row%2, col%2) for each pattern: RGGB, GRBG, GBRG, BGGR.
    tile[0][0] = 0; tile[0][1] = 1; tile[0][2] = 2; tile[0][3] = 3;
    tile[1][0] = 1; tile[1][1] = 0; tile[1][2] = 3; tile[1][3] = 2;
    tile[2][0] = 2; tile[2][1] = 3; tile[2][2] = 0; tile[2][3] = 1;
    tile[3][0] = 3; tile[3][1] = 2; tile[3][2] = 1; tile[3][3] = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({buf_rst, s_ready, buf_en, m_valid, busy, frame_done, cfg_err}),
          32'h40);
    check("rst_tags", 32'({win_row, win_col, cfa_phase}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(4, 4, 0, 100, 100, 1'b0, 0);
    run_frame(4, 4, 0, 100, 100, 1'b1, 0);
    bad_start(2, 4);
    bad_start(4, 2);
    run_frame(4, 4, 1, 100, 100, 1'b0, 7);
    run_frame(4, 4, 1, 100, 100, 1'b0, 0);
    run_frame(5, 3, 3, 100, 100, 1'b0, 0);
    run_frame(3, 3, 2, 100, 100, 1'b0, 0);
    for (int i = 0; i < 3; i++) run_frame(8, 6, int'($urandom_range(3)), 60, 60, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      run_frame(int'($urandom_range(10, 3)), int'($urandom_range(8, 3)), int'($urandom_range(3)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1'b0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
